// File: rtl/decode_control_if.sv
// Instruction fetch bus between decode_control (master) and the instruction source (slave).
interface decode_control_if;
  logic       instrReq;
  logic       instrValid;
  logic [8:0] instruction;

  modport master (output instrReq, input instrValid, input instruction);
  modport slave  (input instrReq, output instrValid, output instruction);
endinterface

// File: rtl/decode_control.sv
// Multi-cycle decode/control FSM driving an 8x8 register file, ALU, data memory and branch unit.
// Optional retired-instruction counter output instrCount is enabled by defining INSTR_COUNT_EN.
module decode_control #(
  parameter int pw  = 3,
  parameter int PCW = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  decode_control_if.master  fetch,
  input  logic [7:0]        readData1,
  output logic [pw-1:0]     readRegister1,
  output logic [pw-1:0]     readRegister2,
  output logic [pw-1:0]     writeRegister,
  output logic              regWrite,
  output logic              immediate,
  output logic [7:0]        ltValue,
  output logic [1:0]        aluOp,
  output logic              memRead,
  output logic              memWrite,
  output logic              memToReg,
  output logic              branchTaken,
  output logic [PCW-1:0]    branchTarget,
`ifdef INSTR_COUNT_EN
  output logic [15:0]       instrCount,
`endif
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [8:0] r_ir;
  logic       r_done;
  logic       w_instr_req;
  logic [2:0] w_opcode;
  logic [2:0] w_idx;

  function automatic logic [7:0] ilut(input logic [2:0] idx);
    case (idx)
      3'd0:    ilut = 8'h00;
      3'd1:    ilut = 8'h01;
      3'd2:    ilut = 8'h02;
      3'd3:    ilut = 8'h04;
      3'd4:    ilut = 8'h08;
      3'd5:    ilut = 8'h10;
      3'd6:    ilut = 8'h7F;
      3'd7:    ilut = 8'hFF;
      default: ilut = 8'h00;
    endcase
  endfunction

  // idx 7 is HALT, so its entry is never driven out
  function automatic logic [PCW-1:0] blut(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'd0;
      3'd1:    v = 8'd4;
      3'd2:    v = 8'd8;
      3'd3:    v = 8'd16;
      3'd4:    v = 8'd32;
      3'd5:    v = 8'd64;
      3'd6:    v = 8'd128;
      default: v = 8'd0;
    endcase
    blut = {{(PCW-8){1'b0}}, v};
  endfunction

  assign w_opcode      = r_ir[8:6];
  assign w_idx         = r_ir[2:0];
  assign readRegister1 = r_ir[5:3];
  assign readRegister2 = r_ir[2:0];
  assign writeRegister = r_ir[5:3];
  assign fetch.instrReq = w_instr_req;
  assign done          = r_done;

  // State, instruction register and done flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= 9'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && fetch.instrValid) begin
        r_ir <= fetch.instruction;
      end
      if (r_state == S_HALTED) begin
        r_done <= 1'b1;
      end else if (r_state == S_IDLE && start) begin
        r_done <= 1'b0;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_instr_req  = 1'b0;
    regWrite     = 1'b0;
    immediate    = 1'b0;
    ltValue      = 8'h00;
    aluOp        = 2'b00;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memToReg     = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = {PCW{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
        else       w_next_state = S_IDLE;
      end
      S_FETCH: begin
        w_instr_req = 1'b1;
        if (fetch.instrValid) w_next_state = S_EXEC;
        else                  w_next_state = S_FETCH;
      end
      S_EXEC: begin
        case (w_opcode)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            aluOp        = w_opcode[1:0];
            regWrite     = 1'b1;
            w_next_state = S_FETCH;
          end
          3'b100: begin
            immediate    = 1'b1;
            ltValue      = ilut(w_idx);
            regWrite     = 1'b1;
            w_next_state = S_FETCH;
          end
          3'b101: begin
            memRead      = 1'b1;
            w_next_state = S_MEM;
          end
          3'b110: begin
            memWrite     = 1'b1;
            w_next_state = S_FETCH;
          end
          3'b111: begin
            if (w_idx == 3'd7) begin
              w_next_state = S_HALTED;
            end else begin
              if (readData1 != 8'h00) begin
                branchTaken  = 1'b1;
                branchTarget = blut(w_idx);
              end else begin
                branchTaken  = 1'b0;
              end
              w_next_state = S_FETCH;
            end
          end
          default: w_next_state = S_IDLE;
        endcase
      end
      S_MEM: begin
        memRead      = 1'b1;
        memToReg     = 1'b1;
        regWrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALTED: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  // LW retires from MEM, every other instruction from EXEC
  assign w_retire   = (r_state == S_EXEC && w_opcode != 3'b101) || (r_state == S_MEM);
  assign instrCount = r_instr_count;

  // Saturating retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr_count <= 16'd0;
    end else if (r_state == S_IDLE && start) begin
      r_instr_count <= 16'd0;
    end else if (w_retire && r_instr_count != 16'hFFFF) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_control.sv
// Directed self-checking bench for decode_control; covers INSTR_COUNT_EN when defined.
module tb_decode_control;
  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  readData1;
  logic [2:0]  readRegister1, readRegister2, writeRegister;
  logic        regWrite, immediate, memRead, memWrite, memToReg, branchTaken, done;
  logic [7:0]  ltValue;
  logic [1:0]  aluOp;
  logic [9:0]  branchTarget;
`ifdef INSTR_COUNT_EN
  logic [15:0] instrCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  decode_control_if fbus ();

  decode_control #(.pw(3), .PCW(10)) dut (
    .clock(clock), .reset(reset), .start(start), .fetch(fbus), .readData1(readData1),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .writeRegister(writeRegister),
    .regWrite(regWrite), .immediate(immediate), .ltValue(ltValue), .aluOp(aluOp),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
`ifdef INSTR_COUNT_EN
    .instrCount(instrCount),
`endif
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the edge, checks happen 2ns after
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  // Serve one instruction after 'stall' empty FETCH cycles; returns positioned in EXEC
  task automatic fetch_instr(input logic [8:0] instr, input int stall);
    for (int i = 0; i < stall; i++) begin
      #1;
      check_eq("stall_req", 64'(fbus.instrReq), 64'd1);
      tick();
    end
    fbus.instrValid  = 1'b1;
    fbus.instruction = instr;
    tick();
    fbus.instrValid  = 1'b0;
    fbus.instruction = 9'd0;
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({fbus.instrReq, readRegister1, readRegister2, writeRegister, regWrite, immediate,
                ltValue, aluOp, memRead, memWrite, memToReg, branchTaken, branchTarget, done});
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; readData1 = 8'h00;
    fbus.instrValid = 1'b0; fbus.instruction = 9'd0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("idle_all_zero", all_outs(), 64'd0);
      tick();
    end
`ifdef INSTR_COUNT_EN
    check_eq("cnt_reset", 64'(instrCount), 64'd0);
`endif

    start_pulse();
    check_eq("fetch_req", 64'(fbus.instrReq), 64'd1);

    // ADD r2, r3
    fetch_instr(9'b000_010_011, 0);
    check_eq("add_rr1", 64'(readRegister1), 64'd2);
    check_eq("add_rr2", 64'(readRegister2), 64'd3);
    check_eq("add_wr", 64'(writeRegister), 64'd2);
    check_eq("add_alu", 64'(aluOp), 64'd0);
    check_eq("add_we", 64'(regWrite), 64'd1);
    check_eq("add_req", 64'(fbus.instrReq), 64'd0);
    tick(); #1;
    check_eq("add_we_off", 64'(regWrite), 64'd0);
    check_eq("add_req_back", 64'(fbus.instrReq), 64'd1);

    // LDI r5, idx6
    fetch_instr(9'b100_101_110, 0);
    check_eq("ldi_imm", 64'(immediate), 64'd1);
    check_eq("ldi_lt", 64'(ltValue), 64'h7F);
    check_eq("ldi_wr", 64'(writeRegister), 64'd5);
    check_eq("ldi_we", 64'(regWrite), 64'd1);
    tick(); #1;
    check_eq("ldi_after", 64'({regWrite, immediate, ltValue}), 64'd0);

    // LW with a 3-cycle fetch stall
    fetch_instr(9'b101_001_100, 3);
    check_eq("lw1_mr", 64'(memRead), 64'd1);
    check_eq("lw1_we_m2r", 64'({regWrite, memToReg}), 64'd0);
    tick(); #1;
    check_eq("lw2_mr", 64'(memRead), 64'd1);
    check_eq("lw2_we_m2r", 64'({regWrite, memToReg}), 64'b11);
    check_eq("lw2_req", 64'(fbus.instrReq), 64'd0);
    tick(); #1;
    check_eq("lw_done_mr", 64'(memRead), 64'd0);
    check_eq("lw_done_req", 64'(fbus.instrReq), 64'd1);

    // SW
    fetch_instr(9'b110_100_001, 0);
    check_eq("sw_we_mw", 64'({regWrite, memWrite}), 64'b01);
    tick(); #1;
    check_eq("sw_off", 64'(memWrite), 64'd0);

    // BNZ taken, then not taken
    readData1 = 8'h05;
    fetch_instr(9'b111_011_010, 0);
    check_eq("bnz_rr1", 64'(readRegister1), 64'd3);
    check_eq("bnz_taken", 64'(branchTaken), 64'd1);
    check_eq("bnz_target", 64'(branchTarget), 64'd8);
    check_eq("bnz_we", 64'({regWrite, memWrite}), 64'd0);
    tick(); #1;
    check_eq("bnz_pulse", 64'(branchTaken), 64'd0);
    readData1 = 8'h00;
    fetch_instr(9'b111_011_010, 0);
    check_eq("bnz_nt", 64'({branchTaken, branchTarget}), 64'd0);
    tick(); #1;

    // SHL opcode
    fetch_instr(9'b011_110_101, 0);
    check_eq("shl_alu", 64'(aluOp), 64'd3);
    tick(); #1;

    // HALT (readData1 nonzero must not produce a branch)
    readData1 = 8'h05;
    fetch_instr(9'b111_000_111, 0);
    check_eq("halt_exec", 64'({branchTaken, regWrite, memWrite, done}), 64'd0);
    tick(); #1;
    check_eq("halted_done", 64'(done), 64'd0);
    tick(); #1;
    readData1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check_eq("done_hold", 64'(done), 64'd1);
      check_eq("done_no_req", 64'(fbus.instrReq), 64'd0);
      tick(); #1;
    end
`ifdef INSTR_COUNT_EN
    check_eq("cnt_first_run", 64'(instrCount), 64'd8);
`endif
    start_pulse();
    check_eq("done_cleared", 64'(done), 64'd0);
`ifdef INSTR_COUNT_EN
    check_eq("cnt_start_clr", 64'(instrCount), 64'd0);
`endif

    // Three instructions then HALT
    fetch_instr(9'b001_001_010, 0);
    check_eq("sub_alu", 64'(aluOp), 64'd1);
    tick(); #1;
    fetch_instr(9'b010_011_100, 0);
    check_eq("and_alu", 64'(aluOp), 64'd2);
    tick(); #1;
    fetch_instr(9'b100_000_111, 0);
    check_eq("ldi_ff", 64'(ltValue), 64'hFF);
    tick(); #1;
    fetch_instr(9'b111_000_111, 0);
    tick(); tick(); #1;
    check_eq("done_run2", 64'(done), 64'd1);
`ifdef INSTR_COUNT_EN
    check_eq("cnt_four", 64'(instrCount), 64'd4);
`endif

    // Reset during EXEC of an ADD
    start_pulse();
    fetch_instr(9'b000_010_011, 0);
    check_eq("rst_pre_we", 64'(regWrite), 64'd1);
    reset = 1'b1;
    tick(); #1;
    check_eq("rst_we", 64'({regWrite, memWrite}), 64'd0);
    reset = 1'b0;
    tick(); #1;
    check_eq("rst_idle", all_outs(), 64'd0);
`ifdef INSTR_COUNT_EN
    check_eq("cnt_rst", 64'(instrCount), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_control.md
Name: decode_control

Overview:
- Multi-cycle instruction decode and control FSM. Sits directly upstream of the 8-entry, 8-bit register file.
- Fetches 9-bit instructions through a req/valid handshake and latches each into an instruction register (IR).
- Drives the register file's read/write addresses, regWrite, immediate and ltValue, plus the ALU op, data-memory strobes and branch requests.
- Runs from a start pulse until HALT, then raises done.

Parameters:
- pw, 3: register address width. 8 registers; ISA fields fixed at 3 bits, so only 3 is legal.
- PCW, 10: branch target width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins execution from IDLE.
- instrValid  in  1  instruction bus holds a valid word.
- instruction  in  9  [8:6] opcode, [5:3] rd, [2:0] rs/idx.
- readData1  in  8  register file read port 1 value, used by BNZ.
- instrReq  out  1  fetch request.
- readRegister1  out  3  = IR[5:3].
- readRegister2  out  3  = IR[2:0].
- writeRegister  out  3  = IR[5:3].
- regWrite  out  1  register file write enable.
- immediate  out  1  high while an LDI is being executed.
- ltValue  out  8  immediate LUT output.
- aluOp  out  2  00 ADD, 01 SUB, 10 AND, 11 SHL.
- memRead  out  1  data memory read strobe.
- memWrite  out  1  data memory write strobe.
- memToReg  out  1  select memory data for write-back.
- branchTaken  out  1  one-cycle branch pulse.
- branchTarget  out  PCW  branch LUT output.
- done  out  1  high after HALT until the next start.

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALTED.
- Control outputs are decoded from state and IR. They are 0 in every state unless listed below.
- Reset values:
  - state=IDLE, IR=0, done=0.
  - All outputs 0, including ltValue and branchTarget.
  - Reset wins over every other input.
  - Reset asserted mid-instruction: no regWrite or memWrite appears in the cycle after the reset edge.
- IDLE: start=1 -> FETCH and clear done. start is ignored in every other state.
- FETCH:
  - instrReq=1.
  - When instrValid=1, IR<=instruction and go to EXEC. Otherwise stay in FETCH.
  - Minimum fetch latency is 1 cycle.
- EXEC, decoded by opcode:
  - 000-011, ALU ops: aluOp=opcode[1:0], regWrite=1 -> FETCH.
  - 100, LDI: immediate=1, ltValue=ILUT[idx], regWrite=1 -> FETCH.
  - 101, LW: memRead=1 -> MEM.
  - 110, SW: memWrite=1 -> FETCH.
  - 111 with idx=7, HALT: -> HALTED.
  - 111 with idx!=7, BNZ: if readData1!=0, branchTaken=1 and branchTarget=BLUT[idx]. -> FETCH either way.
- MEM: memRead=1, memToReg=1, regWrite=1 -> FETCH. LW therefore takes 2 cycles after the fetch.
- HALTED: done<=1 and go to IDLE the next cycle. done stays high until the next start is accepted.
- ILUT[0..7] = 0x00, 0x01, 0x02, 0x04, 0x08, 0x10, 0x7F, 0xFF.
- BLUT[0..6] = 0, 4, 8, 16, 32, 64, 128, zero-extended to PCW.
- readData1 is sampled combinationally in EXEC only.
- At most one of regWrite, memWrite, branchTaken is high in any cycle.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output instrCount[15:0].
  - Increments by 1 on every EXEC->FETCH or EXEC->HALTED transition; an LW counts once.
  - Cleared by reset and when start is accepted. Saturates at 0xFFFF.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 for 5 cycles -> all outputs 0, done=0, instrReq=0.
- ADD timing: start, then instruction=9'b000_010_011 with instrValid=1 -> next cycle readRegister1=2, readRegister2=3, writeRegister=2, aluOp=00, regWrite=1 for exactly 1 cycle, then instrReq=1.
- LDI: instruction 9'b100_101_110 -> immediate=1, ltValue=0x7F, writeRegister=5, regWrite=1 for 1 cycle.
- LW stall plus slow fetch: instrValid held 0 for 3 FETCH cycles, then LW 9'b101_001_100 -> memRead=1 for 2 cycles, regWrite=1 and memToReg=1 only in the second; instrReq stays high throughout the stall.
- BNZ both polarities: 9'b111_011_010 with readData1=0x05 -> branchTaken=1 for 1 cycle, branchTarget=8. With readData1=0x00 -> branchTaken=0.
- HALT and reset mid-op: HALT 9'b111_000_111 -> done=1 and held through start=0; next start clears it. Reset asserted in EXEC of an ADD -> regWrite=0 on the following cycle, state IDLE. With INSTR_COUNT_EN, 3 instructions then HALT -> instrCount=4.
